// File: rtl/axil_arb_pkg.sv
// rtl/axil_arb_pkg.sv - shared types and constants for the AXI-Lite master arbiter
package axil_arb_pkg;

  localparam int DEFAULT_REG_WIDTH = 32;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WRESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin grant with last-grant memory
module rr_arbiter2
  import axil_arb_pkg::*;
(
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_grant;

  // Pick the winner: a lone requester wins, a tie goes to whoever was not served last
  always_comb begin
    grant_id = OWNER_0;
    grant    = 2'b00;
    if (req == 2'b10) begin
      grant_id = OWNER_1;
    end else if (req == 2'b11) begin
      grant_id = (last_grant == OWNER_1) ? OWNER_0 : OWNER_1;
    end
    if (req != 2'b00) begin
      grant = (grant_id == OWNER_1) ? 2'b10 : 2'b01;
    end
  end

  // Remember the owner only when a command is actually taken
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_grant <= OWNER_1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/axil_master_arbiter.sv
// rtl/axil_master_arbiter.sv - shares one AXI-Lite master port between two clients
module axil_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 REQ0_VALID,
  output logic                 REQ0_READY,
  input  logic                 REQ0_WRITE,
  input  logic [REG_WIDTH-1:0] REQ0_ADDR,
  input  logic [REG_WIDTH-1:0] REQ0_WDATA,
  input  logic                 REQ1_VALID,
  output logic                 REQ1_READY,
  input  logic                 REQ1_WRITE,
  input  logic [REG_WIDTH-1:0] REQ1_ADDR,
  input  logic [REG_WIDTH-1:0] REQ1_WDATA,
  output logic                 RSP0_VALID,
  output logic                 RSP1_VALID,
  output logic [REG_WIDTH-1:0] RSP_RDATA,
  output logic [REG_WIDTH-1:0] ARADDR,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  input  logic [REG_WIDTH-1:0] RDATA,
  input  logic                 RVALID,
  output logic                 RREADY,
  output logic [REG_WIDTH-1:0] AWADDR,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [REG_WIDTH-1:0] WDATA,
  output logic                 WVALID,
  input  logic                 WREADY,
  input  logic                 BVALID,
  output logic                 BREADY
);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [REG_WIDTH-1:0] addr_q;
  logic [REG_WIDTH-1:0] wdata_q;
  logic                 owner_q;
  logic                 aw_done;
  logic                 w_done;
  logic [1:0]           req;
  logic [1:0]           grant;
  logic                 grant_id;
  logic                 accept;
  logic                 sel_write;
  logic [REG_WIDTH-1:0] sel_addr;
  logic [REG_WIDTH-1:0] sel_wdata;
  logic                 aw_hs;
  logic                 w_hs;
  logic                 r_hs;
  logic                 b_hs;

  assign req       = {REQ1_VALID, REQ0_VALID};
  assign accept    = (state == ST_IDLE) && (req != 2'b00);
  assign sel_write = (grant_id == OWNER_1) ? REQ1_WRITE : REQ0_WRITE;
  assign sel_addr  = (grant_id == OWNER_1) ? REQ1_ADDR  : REQ0_ADDR;
  assign sel_wdata = (grant_id == OWNER_1) ? REQ1_WDATA : REQ0_WDATA;

  rr_arbiter2 u_rr (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .req      (req),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // READY is held low while reset is asserted so every output reads 0 in reset
  assign REQ0_READY = ARESETN && (state == ST_IDLE) && grant[0];
  assign REQ1_READY = ARESETN && (state == ST_IDLE) && grant[1];

  assign ARVALID = (state == ST_RADDR);
  assign ARADDR  = (state == ST_RADDR) ? addr_q : '0;
  assign RREADY  = (state == ST_RDATA);
  assign AWVALID = (state == ST_WADDR) && !aw_done;
  assign AWADDR  = (state == ST_WADDR) ? addr_q : '0;
  assign WVALID  = (state == ST_WADDR) && !w_done;
  assign WDATA   = (state == ST_WADDR) ? wdata_q : '0;
  assign BREADY  = (state == ST_WRESP);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign r_hs  = RVALID && RREADY;
  assign b_hs  = BVALID && BREADY;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the write phase leaves once both AW and W have handshaken
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = sel_write ? ST_WADDR : ST_RADDR;
      ST_RADDR: if (ARREADY) state_nxt = ST_RDATA;
      ST_RDATA: if (RVALID) state_nxt = ST_IDLE;
      ST_WADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WRESP;
      ST_WRESP: if (BVALID) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winning command at acceptance
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= OWNER_0;
    end else if (accept) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      owner_q <= grant_id;
    end
  end

  // Track AW and W completion separately; cleared whenever the write phase is not active
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != ST_WADDR) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // One-cycle completion pulse to the owner; read data only accompanies a read completion
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
      RSP_RDATA  <= '0;
    end else begin
      RSP0_VALID <= (r_hs || b_hs) && (owner_q == OWNER_0);
      RSP1_VALID <= (r_hs || b_hs) && (owner_q == OWNER_1);
      RSP_RDATA  <= r_hs ? RDATA : '0;
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb/tb_axil_master_arbiter.sv - self-checking bench for axil_master_arbiter
module tb_axil_master_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        REQ0_VALID, REQ0_READY, REQ0_WRITE;
  logic [31:0] REQ0_ADDR, REQ0_WDATA;
  logic        REQ1_VALID, REQ1_READY, REQ1_WRITE;
  logic [31:0] REQ1_ADDR, REQ1_WDATA;
  logic        RSP0_VALID, RSP1_VALID;
  logic [31:0] RSP_RDATA;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;

  always #5 ACLK = ~ACLK;

  axil_master_arbiter #(.REG_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WRITE(REQ0_WRITE),
    .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WRITE(REQ1_WRITE),
    .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
    .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID), .RSP_RDATA(RSP_RDATA),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY)
  );

  typedef struct {
    logic        client;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;     // slave read data to return
    int          aw_st;     // AR stall for reads, AW stall for writes
    int          w_st;
    int          d_st;      // R or B delay
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  int errors = 0;
  int checks = 0;

  logic [31:0] slv_mem [32];
  logic [31:0] model_mem [32];
  logic [31:0] slv_raddr, slv_waddr, slv_wdata;
  bit          rnd_mode;
  int          ar_stall, aw_stall, w_stall, r_dly, b_dly;
  int          ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
  logic        model_last;
  int          grants[$];

  logic        s_v0, s_v1, s_r0, s_r1, s_rsp0, s_rsp1;
  logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
  logic [31:0] s_rdata, s_araddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic clear_counters();
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
  endtask

  task automatic drive_slave();
    if (rnd_mode) begin
      ARREADY = ($urandom_range(0, 2) != 0);
      AWREADY = ($urandom_range(0, 2) != 0);
      WREADY  = ($urandom_range(0, 2) != 0);
      RVALID  = RREADY && ($urandom_range(0, 2) != 0);
      BVALID  = BREADY && ($urandom_range(0, 2) != 0);
    end else begin
      ARREADY = ARVALID && (ar_cnt >= ar_stall);
      AWREADY = AWVALID && (aw_cnt >= aw_stall);
      WREADY  = WVALID && (w_cnt >= w_stall);
      RVALID  = RREADY && (r_cnt >= r_dly);
      BVALID  = BREADY && (b_cnt >= b_dly);
    end
    RDATA = RVALID ? slv_mem[slv_raddr[6:2]] : 32'h0;
  endtask

  // One clock cycle: entered and left at posedge+1, samples everything at posedge+2
  task automatic tick();
    drive_slave();
    #1;
    s_v0 = REQ0_VALID; s_v1 = REQ1_VALID; s_r0 = REQ0_READY; s_r1 = REQ1_READY;
    s_rsp0 = RSP0_VALID; s_rsp1 = RSP1_VALID; s_rdata = RSP_RDATA;
    s_arvalid = ARVALID; s_araddr = ARADDR; s_awvalid = AWVALID; s_wvalid = WVALID;
    s_rready = RREADY; s_bready = BREADY;
    if (ARVALID && ARREADY) slv_raddr = ARADDR;
    if (AWVALID && AWREADY) slv_waddr = AWADDR;
    if (WVALID && WREADY) slv_wdata = WDATA;
    if (BVALID && BREADY) slv_mem[slv_waddr[6:2]] = slv_wdata;
    ar_cnt = (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
    aw_cnt = (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
    w_cnt  = (WVALID && !WREADY) ? w_cnt + 1 : 0;
    r_cnt  = (RREADY && !RVALID) ? r_cnt + 1 : 0;
    b_cnt  = (BREADY && !BVALID) ? b_cnt + 1 : 0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_req(input logic c, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    if (c) begin
      REQ1_VALID = v; REQ1_WRITE = wr; REQ1_ADDR = a; REQ1_WDATA = d;
    end else begin
      REQ0_VALID = v; REQ0_WRITE = wr; REQ0_ADDR = a; REQ0_WDATA = d;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctrl"}, {REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, ARVALID,
                         RREADY, AWVALID, WVALID, BREADY}, 0);
    chk({tag, " rsp_rdata"}, RSP_RDATA, 0);
    chk({tag, " addr/data"}, {ARADDR, AWADDR} | {32'h0, WDATA}, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acc_c = -1;
    int rsp_c = -1;
    logic rc = 1'b0;
    logic [31:0] rd = 32'h0;
    int ar_hi = 0, aw_hi = 0, w_hi = 0, busy_rdy = 0, addr_bad = 0, wrong = 0;
    rnd_mode = 0;
    ar_stall = v.aw_st; aw_stall = v.aw_st; w_stall = v.w_st; r_dly = v.d_st; b_dly = v.d_st;
    clear_counters();
    if (!v.write) slv_mem[v.addr[6:2]] = v.rdata;
    set_req(!v.client, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(v.client, 1'b1, v.write, v.addr, v.wdata);
    for (int c = 0; c < 60 && rsp_c < 0; c++) begin
      tick();
      if (acc_c >= 0 && (s_r0 || s_r1)) busy_rdy++;
      if (s_arvalid) begin
        ar_hi++;
        if (s_araddr !== v.addr) addr_bad++;
      end
      if (s_awvalid) aw_hi++;
      if (s_wvalid) w_hi++;
      if (acc_c < 0 && ((s_v0 && s_r0) || (s_v1 && s_r1))) begin
        if ((v.client ? s_r1 : s_r0) !== 1'b1) wrong++;
        acc_c = c;
        model_last = v.client;
        set_req(v.client, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (s_rsp0 || s_rsp1) begin
        rsp_c = c;
        rc = s_rsp1;
        rd = s_rdata;
        if (s_rsp0 && s_rsp1) wrong++;
      end
    end
    chk({tag, " completed"}, (rsp_c >= 0 && acc_c >= 0), 1);
    chk({tag, " latency"}, rsp_c - acc_c, v.exp_lat);
    chk({tag, " rsp client"}, rc, v.client);
    chk({tag, " rsp rdata"}, rd, v.exp_rdata);
    chk({tag, " addr valid cycles"}, v.write ? aw_hi : ar_hi, v.aw_st + 1);
    chk({tag, " araddr stable"}, addr_bad, 0);
    chk({tag, " ready while busy"}, busy_rdy, 0);
    chk({tag, " wrong client"}, wrong, 0);
    if (v.write) begin
      chk({tag, " wvalid cycles"}, w_hi, v.w_st + 1);
      chk({tag, " slave mem"}, slv_mem[v.addr[6:2]], v.wdata);
    end
  endtask

  // Transaction-level model: round-robin winner rule, one outstanding command, memory view
  task automatic run_traffic(input int n0, input int n1, input bit random_cmds, input bit always_on);
    cmd_t q0[$];
    cmd_t q1[$];
    cmd_t cmd;
    bit on0 = 0, on1 = 0, out_v = 0;
    logic out_c = 1'b0;
    logic [31:0] out_rd = 32'h0;
    logic exp_r0, exp_r1;
    for (int i = 0; i < n0 + n1; i++) begin
      cmd.write = random_cmds ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd.addr  = 32'h40 + 32'(4 * (random_cmds ? $urandom_range(0, 7) : (i % 8)));
      cmd.wdata = $urandom;
      if (i < n0) q0.push_back(cmd); else q1.push_back(cmd);
    end
    clear_counters();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (q0.size() == 0 && q1.size() == 0 && !out_v) break;
      if (!on0 && q0.size() > 0 && (always_on || $urandom_range(0, 1) == 1)) on0 = 1;
      if (!on1 && q1.size() > 0 && (always_on || $urandom_range(0, 1) == 1)) on1 = 1;
      if (on0) set_req(1'b0, 1'b1, q0[0].write, q0[0].addr, q0[0].wdata);
      else     set_req(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (on1) set_req(1'b1, 1'b1, q1[0].write, q1[0].addr, q1[0].wdata);
      else     set_req(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      tick();
      if (s_rsp0 || s_rsp1) begin
        chk("traffic rsp owner", {s_rsp1, s_rsp0}, out_v ? (out_c ? 2'b10 : 2'b01) : 2'b00);
        chk("traffic rsp rdata", s_rdata, out_rd);
        out_v = 0;
      end
      exp_r0 = !out_v && s_v0 && (!s_v1 || model_last);
      exp_r1 = !out_v && s_v1 && (!s_v0 || !model_last);
      chk("traffic ready", {s_r1, s_r0}, {exp_r1, exp_r0});
      if ((s_v0 && s_r0) || (s_v1 && s_r1)) begin
        if (s_v0 && s_r0) begin
          cmd = q0.pop_front(); on0 = 0; out_c = 1'b0;
        end else begin
          cmd = q1.pop_front(); on1 = 0; out_c = 1'b1;
        end
        grants.push_back(int'(out_c));
        model_last = out_c;
        out_v = 1;
        if (cmd.write) begin
          model_mem[cmd.addr[6:2]] = cmd.wdata;
          out_rd = 32'h0;
        end else begin
          out_rd = model_mem[cmd.addr[6:2]];
        end
      end
    end
    chk("traffic drained", q0.size() + q1.size() + int'(out_v), 0);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int exp_g[6];
    int pulses;
    tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0, 3, 32'hDEADBEEF};
    tbl[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0, 0, 2, 0, 5, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 32'h14, 32'h0, 32'hCAFEF00D, 5, 0, 0, 8, 32'hCAFEF00D};
    tbl[3] = '{1'b1, 1'b0, 32'h18, 32'h0, 32'h0BADF00D, 0, 0, 3, 6, 32'h0BADF00D};
    tbl[4] = '{1'b0, 1'b1, 32'h1C, 32'hA1B2C3D4, 32'h0, 3, 1, 2, 8, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 32'h24, 32'h5555AAAA, 32'h0, 0, 0, 0, 3, 32'h0};
    exp_g = '{0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 32; i++) begin
      slv_mem[i] = init_val(i);
      model_mem[i] = init_val(i);
    end
    slv_raddr = 0; slv_waddr = 0; slv_wdata = 0;
    rnd_mode = 0; ar_stall = 0; aw_stall = 0; w_stall = 0; r_dly = 0; b_dly = 0;
    clear_counters();
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0; RDATA = 0;
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    ARESETN = 1'b0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge ACLK);
    #1;
    REQ0_VALID = 1'b0;
    ARESETN = 1'b1;
    model_last = 1'b1;

    // Both clients contend from reset with three reads each
    grants.delete();
    run_traffic(3, 3, 1'b0, 1'b1);
    chk("tie grant count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk($sformatf("tie grant %0d", i), grants[i], exp_g[i]);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for read data
    rnd_mode = 0; ar_stall = 0; r_dly = 30; clear_counters();
    s_rready = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int c = 0; c < 20 && !s_rready; c++) begin
      tick();
      if (s_v0 && s_r0) REQ0_VALID = 1'b0;
    end
    chk("midrst reached rdata", s_rready, 1);
    ARESETN = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge ACLK);
    #1;
    tick();
    ARESETN = 1'b1;
    model_last = 1'b1;
    clear_counters();
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_rsp0 || s_rsp1) pulses++;
    end
    chk("midrst stale rsp", pulses, 0);
    run_vec(tbl[0], "post-reset read");

    // Randomized traffic against the transaction model
    rnd_mode = 1;
    run_traffic(40, 40, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
